// File: rtl/ax3_seg_scan.sv
// Purpose: multiplexed scanner for the AX309 six-digit seven-segment display.
// Latency: hex/hsel/slot are registered and change 1 clk after the qualifying ena_us edge.
// Backpressure: none; the scan free-runs on ena_us and blank only masks the outputs.
module ax3_seg_scan #(
    parameter int NDIG     = 6,
    parameter int SLOT_US  = 1000,
    parameter int BLANK_US = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_us,
    input  logic [7:0] seg_hex0,
    input  logic [7:0] seg_hex1,
    input  logic [7:0] seg_hex2,
    input  logic [7:0] seg_hex3,
    input  logic [2:0] bri,
    input  logic       blank,
    output logic [7:0] hex,
    output logic [5:0] hsel,
    output logic [2:0] slot
);

    // Tick counter spans one slot; lit length must also be able to hold SLOT_US itself.
    localparam int CW   = $clog2(SLOT_US);
    localparam int LW   = $clog2(SLOT_US + 1);
    localparam int UNIT = (SLOT_US - BLANK_US) >> 3;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    slot_nxt, slot_dec, ld_slot;
    logic [7:0]    dat, dat_nxt, ld_mask;
    logic [LW-1:0] len, len_nxt, len_calc, on_elapsed;
    logic          primed;
    logic          slot_end, load, dark;
    logic [7:0]    hex_nxt;
    logic [5:0]    hsel_nxt;

    // Next-state: counter, slot rotation, slot-start snapshot and BLANK/ON/OFF sequencing.
    always_comb begin
        slot_end   = ena_us && (cnt == CW'(SLOT_US - 1));
        slot_dec   = (slot == 3'd0) ? 3'(NDIG - 1) : slot - 3'd1;
        // Slot 0 has no preceding slot end, so its snapshot happens on the first tick.
        load       = slot_end || (ena_us && !primed);
        ld_slot    = slot_end ? slot_dec : slot;
        len_calc   = LW'(UNIT) * (LW'(bri) + LW'(1));
        on_elapsed = LW'(cnt) + LW'(1) - LW'(BLANK_US);

        case (ld_slot)
            3'd0:    ld_mask = seg_hex0;
            3'd1:    ld_mask = seg_hex1;
            3'd2:    ld_mask = seg_hex2;
            3'd3:    ld_mask = seg_hex3;
            default: ld_mask = 8'h00;
        endcase

        state_nxt = state;
        cnt_nxt   = cnt;
        slot_nxt  = slot;
        dat_nxt   = dat;
        len_nxt   = len;

        if (slot_end) begin
            cnt_nxt   = '0;
            slot_nxt  = slot_dec;
            state_nxt = ST_BLANK;
        end else if (ena_us) begin
            cnt_nxt = cnt + CW'(1);
            case (state)
                ST_BLANK: if (cnt == CW'(BLANK_US - 1)) state_nxt = ST_ON;
                ST_ON:    if (on_elapsed == len) state_nxt = ST_OFF;
                default:  state_nxt = state;
            endcase
        end

        if (load) begin
            dat_nxt = ld_mask;
            len_nxt = len_calc;
        end

        dark     = blank || (state_nxt != ST_ON);
        hex_nxt  = dark ? 8'hFF : ~dat_nxt;
        hsel_nxt = dark ? 6'h3F : ~(6'b000001 << slot_nxt);
    end

    // State and registered pin drive, all updated on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_BLANK;
            cnt    <= '0;
            slot   <= 3'd0;
            dat    <= 8'h00;
            len    <= '0;
            primed <= 1'b0;
            hex    <= 8'hFF;
            hsel   <= 6'h3F;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            slot   <= slot_nxt;
            dat    <= dat_nxt;
            len    <= len_nxt;
            primed <= primed | ena_us;
            hex    <= hex_nxt;
            hsel   <= hsel_nxt;
        end
    end

endmodule

// File: tb/tb_ax3_seg_scan.sv
// Bench for ax3_seg_scan: random tick spacing and inputs against a tick-count reference.
// Expected outputs derive from the tick number since reset and per-slot snapshots.
// Inputs change on negedges, outputs are sampled on negedges.
module tb_ax3_seg_scan;

    localparam int NDIG = 6;
    localparam int S    = 1000;
    localparam int B    = 20;
    localparam int UNIT = (S - B) >> 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena_us;
    logic [7:0] seg_hex0, seg_hex1, seg_hex2, seg_hex3;
    logic [2:0] bri;
    logic       blank;
    logic [7:0] hex;
    logic [5:0] hsel;
    logic [2:0] slot;

    int checks   = 0;
    int failures = 0;

    // reference state: ticks since reset and the snapshot of the current slot
    int         k;
    int         m_len;
    int         m_pos;
    logic [7:0] m_dat;

    ax3_seg_scan #(.NDIG(NDIG), .SLOT_US(S), .BLANK_US(B)) dut (
        .clk(clk), .rst_n(rst_n), .ena_us(ena_us),
        .seg_hex0(seg_hex0), .seg_hex1(seg_hex1), .seg_hex2(seg_hex2), .seg_hex3(seg_hex3),
        .bri(bri), .blank(blank), .hex(hex), .hsel(hsel), .slot(slot)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        k = 0; m_len = 0; m_pos = 0; m_dat = 8'h00;
    endtask

    // One microsecond elapsed: a new slot takes its snapshot from the inputs at that tick.
    task automatic model_tick();
        int c, s;
        k++;
        c = k % S;
        s = k / S;
        if (k == 1 || c == 0) begin
            m_pos = (NDIG - (s % NDIG)) % NDIG;
            m_len = UNIT * (int'(bri) + 1);
            case (m_pos)
                0: m_dat = seg_hex0;
                1: m_dat = seg_hex1;
                2: m_dat = seg_hex2;
                3: m_dat = seg_hex3;
                default: m_dat = 8'h00;
            endcase
        end
    endtask

    function automatic bit model_lit();
        int c;
        c = k % S;
        return (c >= B) && (c < B + m_len) && !blank;
    endfunction

    function automatic logic [7:0] exp_hex();
        return model_lit() ? ~m_dat : 8'hFF;
    endfunction

    function automatic logic [5:0] exp_hsel();
        logic [5:0] one;
        one = 6'b000001;
        return model_lit() ? ~(one << m_pos) : 6'h3F;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; ena_us = 1'b0; blank = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Issue n ticks (gapmax 0: ena_us held high), collecting mismatches and lit samples.
    task automatic run(input int n, input int gapmax, input bit rnd,
                       output int bad, output int lit, output string first);
        bad = 0; lit = 0; first = "";
        for (int i = 0; i < n; i++) begin
            ena_us = 1'b1;
            @(negedge clk);
            model_tick();
            if (hex !== exp_hex() || hsel !== exp_hsel() || slot !== 3'(m_pos)) begin
                if (bad == 0)
                    first = $sformatf("tick %0d hex=%h/%h hsel=%h/%h slot=%0d/%0d",
                                      k, hex, exp_hex(), hsel, exp_hsel(), slot, m_pos);
                bad++;
            end
            if (hsel !== 6'h3F) lit++;
            if (rnd && $urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: seg_hex0 = 8'($urandom);
                    1: seg_hex1 = 8'($urandom);
                    2: seg_hex2 = 8'($urandom);
                    3: seg_hex3 = 8'($urandom);
                    default: bri = 3'($urandom);
                endcase
            end
            if (gapmax > 0) begin
                ena_us = 1'b0;
                repeat ($urandom_range(0, gapmax)) begin
                    @(negedge clk);
                    if (hex !== exp_hex() || hsel !== exp_hsel()) begin
                        if (bad == 0)
                            first = $sformatf("idle after tick %0d hex=%h/%h hsel=%h/%h",
                                              k, hex, exp_hex(), hsel, exp_hsel());
                        bad++;
                    end
                end
            end
        end
        ena_us = 1'b0;
    endtask

    task automatic test_reset();
        seg_hex0 = 8'($urandom); seg_hex1 = 8'($urandom);
        seg_hex2 = 8'($urandom); seg_hex3 = 8'($urandom); bri = 3'($urandom);
        do_reset();
        repeat (3) @(negedge clk);
        checks++; if (hex !== 8'hFF) begin failures++; $display("FAIL reset_hex: got %h want ff", hex); end
        checks++; if (hsel !== 6'h3F) begin failures++; $display("FAIL reset_hsel: got %h want 3f", hsel); end
        checks++; if (slot !== 3'd0) begin failures++; $display("FAIL reset_slot: got %0d want 0", slot); end
    endtask

    task automatic test_first_slot();
        int bad, lit; string f;
        seg_hex0 = 8'h3F; bri = 3'd7;
        do_reset();
        run(19, 2, 1'b0, bad, lit, f);
        checks++; if (lit !== 0) begin failures++; $display("FAIL first_blank_lit: got %0d want 0", lit); end
        run(976, 2, 1'b0, bad, lit, f);
        checks++; if (lit !== 976) begin failures++; $display("FAIL first_on_len: got %0d want 976", lit); end
        checks++; if (hex !== 8'hC0 || hsel !== 6'h3E) begin
            failures++; $display("FAIL first_on_value: got %h/%h want c0/3e", hex, hsel); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL first_on_model: mismatches=%0d want 0 (%s)", bad, f); end
        run(5, 2, 1'b0, bad, lit, f);
        checks++; if (lit !== 0 || bad !== 0) begin
            failures++; $display("FAIL first_tail_dark: lit=%0d bad=%0d want 0/0", lit, bad); end
    endtask

    task automatic test_full_scan();
        int bad, lit, badsum; string f, fs;
        logic [2:0] want_seq [7];
        logic [2:0] got_seq [7];
        logic [5:0] got_hsel [7];
        logic [7:0] got_hex [7];
        want_seq = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        seg_hex0 = 8'($urandom); seg_hex1 = 8'($urandom);
        seg_hex2 = 8'($urandom); seg_hex3 = 8'($urandom); bri = 3'd7;
        do_reset();
        badsum = 0; fs = "";
        for (int j = 0; j < 7; j++) begin
            run(500, 1, 1'b0, bad, lit, f);
            if (bad != 0 && badsum == 0) fs = f;
            badsum += bad;
            got_seq[j] = slot; got_hsel[j] = hsel; got_hex[j] = hex;
            run(500, 1, 1'b0, bad, lit, f);
            if (bad != 0 && badsum == 0) fs = f;
            badsum += bad;
        end
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (got_seq[j] !== want_seq[j]) begin
                failures++; $display("FAIL scan_order[%0d]: got %0d want %0d", j, got_seq[j], want_seq[j]); end
        end
        checks++; if (got_hsel[1] !== 6'h1F || got_hex[1] !== 8'hFF) begin
            failures++; $display("FAIL scan_pos5: got %h/%h want ff/1f", got_hex[1], got_hsel[1]); end
        checks++; if (got_hsel[2] !== 6'h2F || got_hex[2] !== 8'hFF) begin
            failures++; $display("FAIL scan_pos4: got %h/%h want ff/2f", got_hex[2], got_hsel[2]); end
        checks++; if (badsum !== 0) begin failures++; $display("FAIL scan_model: mismatches=%0d want 0 (%s)", badsum, fs); end
    endtask

    task automatic test_brightness();
        int bad, lit, lit2; string f;
        seg_hex0 = 8'($urandom); bri = 3'd0;
        do_reset();
        run(1000, 2, 1'b0, bad, lit, f);
        checks++; if (lit !== 122) begin failures++; $display("FAIL bri0_len: got %0d want 122", lit); end
        run(100, 2, 1'b0, bad, lit, f);
        bri = 3'd5;
        run(900, 2, 1'b0, bad, lit2, f);
        checks++; if (lit + lit2 !== 122) begin
            failures++; $display("FAIL bri_midslot_len: got %0d want 122", lit + lit2); end
        run(1000, 2, 1'b0, bad, lit, f);
        checks++; if (lit !== 732) begin failures++; $display("FAIL bri5_next_len: got %0d want 732", lit); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bri_model: mismatches=%0d want 0 (%s)", bad, f); end
    endtask

    task automatic test_tearing();
        int bad, lit; string f;
        logic [7:0] va, vb;
        va = 8'($urandom) | 8'h01;
        vb = ~va;
        seg_hex1 = va; bri = 3'd7;
        do_reset();
        run(5500, 0, 1'b0, bad, lit, f);
        checks++; if (slot !== 3'd1 || hex !== ~va || hsel !== 6'h3D) begin
            failures++; $display("FAIL tear_lit_old: got %0d/%h/%h want 1/%h/3d", slot, hex, hsel, ~va); end
        seg_hex1 = vb;
        run(300, 0, 1'b0, bad, lit, f);
        checks++; if (hex !== ~va) begin failures++; $display("FAIL tear_hold: got %h want %h", hex, ~va); end
        run(5700, 0, 1'b0, bad, lit, f);
        checks++; if (slot !== 3'd1 || hex !== ~vb) begin
            failures++; $display("FAIL tear_new: got %0d/%h want 1/%h", slot, hex, ~vb); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL tear_model: mismatches=%0d want 0 (%s)", bad, f); end
    endtask

    task automatic test_blank();
        int bad, lit; string f;
        seg_hex0 = 8'($urandom) | 8'h80; bri = 3'd7;
        do_reset();
        run(100, 2, 1'b0, bad, lit, f);
        blank = 1'b1;
        @(negedge clk);
        checks++; if (hex !== 8'hFF || hsel !== 6'h3F) begin
            failures++; $display("FAIL blank_force: got %h/%h want ff/3f", hex, hsel); end
        run(50, 2, 1'b0, bad, lit, f);
        checks++; if (lit !== 0 || bad !== 0) begin
            failures++; $display("FAIL blank_hold: lit=%0d bad=%0d want 0/0", lit, bad); end
        blank = 1'b0;
        @(negedge clk);
        checks++; if (hex !== ~seg_hex0 || hsel !== 6'h3E) begin
            failures++; $display("FAIL blank_release: got %h/%h want %h/3e", hex, hsel, ~seg_hex0); end
        run(1900, 2, 1'b0, bad, lit, f);
        checks++; if (bad !== 0) begin failures++; $display("FAIL blank_phase: mismatches=%0d want 0 (%s)", bad, f); end
    endtask

    task automatic test_async_reset();
        int bad, lit; string f;
        seg_hex3 = 8'($urandom) | 8'h01; bri = 3'd7;
        do_reset();
        run(3500, 0, 1'b0, bad, lit, f);
        checks++; if (slot !== 3'd3 || hsel !== 6'h37) begin
            failures++; $display("FAIL arst_pre: got %0d/%h want 3/37", slot, hsel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hex !== 8'hFF || hsel !== 6'h3F || slot !== 3'd0) begin
            failures++; $display("FAIL arst_now: got %h/%h/%0d want ff/3f/0", hex, hsel, slot); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (slot !== 3'd0 || hsel !== 6'h3F) begin
            failures++; $display("FAIL arst_release: got %0d/%h want 0/3f", slot, hsel); end
        run(1200, 1, 1'b0, bad, lit, f);
        checks++; if (bad !== 0) begin failures++; $display("FAIL arst_rerun: mismatches=%0d want 0 (%s)", bad, f); end
    endtask

    task automatic test_back_to_back();
        int bad, lit; string f;
        seg_hex0 = 8'($urandom); seg_hex1 = 8'($urandom);
        seg_hex2 = 8'($urandom); seg_hex3 = 8'($urandom); bri = 3'($urandom);
        do_reset();
        run(6000, 0, 1'b1, bad, lit, f);
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_random: mismatches=%0d want 0 (%s)", bad, f); end
        run(6000, 3, 1'b1, bad, lit, f);
        checks++; if (bad !== 0) begin failures++; $display("FAIL gapped_random: mismatches=%0d want 0 (%s)", bad, f); end
    endtask

    initial begin
        rst_n = 1'b0; ena_us = 1'b0; blank = 1'b0; bri = 3'd0;
        seg_hex0 = 8'h00; seg_hex1 = 8'h00; seg_hex2 = 8'h00; seg_hex3 = 8'h00;
        model_reset();
        test_reset();
        test_first_slot();
        test_full_scan();
        test_brightness();
        test_tearing();
        test_blank();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
